// File: rtl/bit_pattern_gen_pkg.sv
// bit_pattern_gen_pkg: shared state encoding and default sizes for the serial pattern generator
package bit_pattern_gen_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_MATCH_W = 8;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/bit_pattern_gen_fall_edge_counter.sv
// fall_edge_counter: saturating count of 1->0 transitions on a bit stream, cleared per frame
module fall_edge_counter
  import bit_pattern_gen_pkg::*;
#(
  parameter int MATCH_W = DEF_MATCH_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_enable,
  input  logic               i_bit,
  output logic [MATCH_W-1:0] o_count
);
  logic               r_prev;
  logic [MATCH_W-1:0] r_count;
  // i_bit is the value about to be registered onto the line, so the count moves in step with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev  <= 1'b0;
      r_count <= '0;
    end else begin
      r_prev <= i_bit;
      if (i_clear) r_count <= '0;
      else if (i_enable && r_prev && !i_bit && !(&r_count)) r_count <= r_count + 1'b1;
    end
  end
  assign o_count = r_count;
endmodule

// File: rtl/bit_pattern_gen.sv
// bit_pattern_gen: shifts a captured pattern out MSB-first, repeated with one-cycle gaps,
// and counts the 1->0 transitions it drives
module bit_pattern_gen
  import bit_pattern_gen_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MATCH_W = DEF_MATCH_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   pattern,
  input  logic [CNT_W-1:0]   repeats,
  output logic               out,
  output logic               out_valid,
  output logic               busy,
  output logic               done,
  output logic [MATCH_W-1:0] edge_cnt
);
  localparam int BIT_W = $clog2(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_pat;
  logic [CNT_W-1:0] r_rep;
  logic [BIT_W-1:0] r_bit;
  logic             r_out;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_out_nxt;
  logic             w_last;
  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_out_nxt = (r_state == ST_SHIFT) && r_shreg[WIDTH-1];
  assign w_last    = r_bit == BIT_W'(WIDTH - 1);
  // outputs lag the state by one edge: each state's cycle sets what the line shows next
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_pat   <= '0;
      r_rep   <= '0;
      r_bit   <= '0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_out   <= 1'b0;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          if (start) begin
            r_shreg <= pattern;
            r_pat   <= pattern;
            r_rep   <= repeats;
            r_bit   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_out   <= r_shreg[WIDTH-1];
          r_valid <= 1'b1;
          r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
          r_bit   <= r_bit + 1'b1;
          if (w_last) begin
            r_bit <= '0;
            if (r_rep == '0) r_state <= ST_DONE;
            else begin
              r_rep   <= r_rep - 1'b1;
              r_shreg <= r_pat;
              r_state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          r_out   <= 1'b0;
          r_valid <= 1'b0;
          r_state <= ST_SHIFT;
        end
        ST_DONE: begin
          r_out   <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
  fall_edge_counter #(.MATCH_W(MATCH_W)) u_fall (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_accept),
    .i_enable(r_state != ST_IDLE),
    .i_bit   (w_out_nxt),
    .o_count (edge_cnt)
  );
  assign out       = r_out;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;
endmodule

// File: tb/tb_bit_pattern_gen.sv
// tb_bit_pattern_gen: directed frames with hand-derived line sequences and 1->0 counts
module tb_bit_pattern_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] repeats = '0;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic [3:0] edge_cnt;
  int         errors = 0;
  int         checks = 0;
  bit_pattern_gen #(.WIDTH(8), .CNT_W(4), .MATCH_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pattern  (pattern),
    .repeats  (repeats),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done),
    .edge_cnt (edge_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int model_edges(input logic [7:0] pat, input int rep);
    int   n = 0;
    logic p = 1'b0;
    for (int r = 0; r <= rep; r++) begin
      for (int b = 7; b >= 0; b--) begin
        if (p && !pat[b]) n++;
        p = pat[b];
      end
      if (p) n++;
      p = 1'b0;
    end
    return n > 15 ? 15 : n;
  endfunction
  // k counts negedges after the accept edge; {out,out_valid,busy,done} is compared every cycle
  task automatic run_frame(input logic [7:0] pat, input int rep, input int poke_k);
    int         len = (rep + 1) * 9;
    int         det = 0;
    int         p;
    logic       prev = 1'b0;
    logic [3:0] exp;
    @(negedge clk);
    start = 1'b1;
    pattern = pat;
    repeats = 4'(rep);
    @(negedge clk);
    start = 1'b0;
    pattern = 8'($urandom);
    repeats = 4'($urandom);
    check("accept", {out, out_valid, busy, done}, 4'b0010);
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      start = k == poke_k;
      if (k == poke_k) pattern = 8'h0F;
      p = (k - 1) % 9;
      exp = k == len + 1 ? 4'b0000 : k == len ? 4'b0001 : p < 8 ? {pat[7-p], 3'b110} : 4'b0010;
      check($sformatf("pat%02h_cyc%0d", pat, k), {out, out_valid, busy, done}, exp);
      if (prev && !out) det++;
      prev = out;
      if (k >= len) check($sformatf("pat%02h_edge_cnt", pat), edge_cnt, model_edges(pat, rep));
      if (k == len) check($sformatf("pat%02h_loopback", pat), edge_cnt, det > 15 ? 15 : det);
    end
    start = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("reset_outs", {out, out_valid, busy, done}, 4'b0000);
    check("reset_edge_cnt", edge_cnt, 0);
    rst = 1'b1;
    run_frame(8'b1011_0010, 0, 0);
    run_frame(8'hFF, 1, 0);
    run_frame(8'hAA, 15, 0);
    run_frame(8'hC3, 0, 3);
    @(negedge clk);
    start = 1'b1;
    pattern = 8'hB6;
    repeats = 4'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset", {out, edge_cnt}, {1'b1, 4'd1});
    rst = 1'b0;
    #1;
    check("mid_reset", {out, out_valid, busy, done, edge_cnt}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("after_reset", {out, out_valid, busy, done}, 4'b0000);
    end
    run_frame(8'h80, 0, 0);
    for (int i = 0; i < 6; i++) run_frame(8'($urandom), int'($urandom_range(0, 1)), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
